// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register of the pipelined MIPS core. Each cycle it captures
// the decoded control bundle, register operands, sign-extended immediate,
// PC+4 and register specifiers into the EX-stage register. It also detects
// load-use hazards against the load already in EX. On such a hazard, or on a
// branch flush, it inserts a bubble.
//
// Ports
//   Clk, Rst_n            rising-edge clock, asynchronous active-low reset
//   Id_Valid              ID holds a real instruction
//   Flush                 branch taken: kill the ID instruction
//   RegDst..RegWrite      control bundle from the control unit
//   ALUOp[3:0]            ALU control code
//   ReadData1/2, SignExt  operands and immediate (DATA_W)
//   PCPlus4               PC+4 of the ID instruction (DATA_W)
//   Id_Rs/Rt/Rd           register specifiers (REG_W)
//   Ex_*                  registered EX-stage copies of the above
//   Ex_Valid              EX holds a real instruction
//   Stall                 combinational: hold PC and IF/ID this cycle
//   StallCount            saturating count of load-use bubbles
//
// Stall semantics: Stall is a level, not a handshake. While Stall=1 the
// upstream stages must keep the same instruction on the ID inputs. At the
// next edge this stage takes a bubble, which clears Ex_MemRead and drops
// Stall. A single hazard therefore costs exactly one cycle. Stall is derived
// only from registered EX state and the current ID inputs, so it never feeds
// back into the hazard term.
// ---------------------------------------------------------------------------
module id_ex_stage #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int CNT_W  = 16
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              Id_Valid,
   input  logic              Flush,
   input  logic              RegDst,
   input  logic              Branch,
   input  logic              MemRead,
   input  logic              MemtoReg,
   input  logic              MemWrite,
   input  logic              ALUSrc,
   input  logic              RegWrite,
   input  logic [3:0]        ALUOp,
   input  logic [DATA_W-1:0] ReadData1,
   input  logic [DATA_W-1:0] ReadData2,
   input  logic [DATA_W-1:0] SignExt,
   input  logic [DATA_W-1:0] PCPlus4,
   input  logic [REG_W-1:0]  Id_Rs,
   input  logic [REG_W-1:0]  Id_Rt,
   input  logic [REG_W-1:0]  Id_Rd,
   output logic              Ex_RegDst,
   output logic              Ex_Branch,
   output logic              Ex_MemRead,
   output logic              Ex_MemtoReg,
   output logic              Ex_MemWrite,
   output logic              Ex_ALUSrc,
   output logic              Ex_RegWrite,
   output logic [3:0]        Ex_ALUOp,
   output logic [DATA_W-1:0] Ex_ReadData1,
   output logic [DATA_W-1:0] Ex_ReadData2,
   output logic [DATA_W-1:0] Ex_SignExt,
   output logic [DATA_W-1:0] Ex_PCPlus4,
   output logic [REG_W-1:0]  Ex_Rs,
   output logic [REG_W-1:0]  Ex_Rt,
   output logic [REG_W-1:0]  Ex_Rd,
   output logic              Ex_Valid,
   output logic              Stall,
   output logic [CNT_W-1:0]  StallCount
);

   logic uses_rt;
   logic rs_match;
   logic rt_match;
   logic hz;
   logic bubble;

   // Rt is a source for R-type, BEQ (ALUSrc=0) and SW (store data).
   // Loads to $zero never produce a value, so they never stall.
   always_comb begin
      uses_rt  = ~ALUSrc | MemWrite;
      rs_match = (Ex_Rt == Id_Rs);
      rt_match = uses_rt & (Ex_Rt == Id_Rt);
      hz       = Ex_Valid & Ex_MemRead & (Ex_Rt != '0) & Id_Valid &
                 (rs_match | rt_match);
      Stall    = hz & ~Flush;
      bubble   = Flush | hz;
   end

   // Control half: a bubble clears valid and every control bit. A non-valid
   // ID slot loads zero controls, so EX never acts on a dead instruction.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         Ex_Valid    <= 1'b0;
         Ex_RegDst   <= 1'b0;
         Ex_Branch   <= 1'b0;
         Ex_MemRead  <= 1'b0;
         Ex_MemtoReg <= 1'b0;
         Ex_MemWrite <= 1'b0;
         Ex_ALUSrc   <= 1'b0;
         Ex_RegWrite <= 1'b0;
         Ex_ALUOp    <= 4'd0;
      end else if (bubble) begin
         Ex_Valid    <= 1'b0;
         Ex_RegDst   <= 1'b0;
         Ex_Branch   <= 1'b0;
         Ex_MemRead  <= 1'b0;
         Ex_MemtoReg <= 1'b0;
         Ex_MemWrite <= 1'b0;
         Ex_ALUSrc   <= 1'b0;
         Ex_RegWrite <= 1'b0;
         Ex_ALUOp    <= 4'd0;
      end else begin
         Ex_Valid    <= Id_Valid;
         Ex_RegDst   <= RegDst   & Id_Valid;
         Ex_Branch   <= Branch   & Id_Valid;
         Ex_MemRead  <= MemRead  & Id_Valid;
         Ex_MemtoReg <= MemtoReg & Id_Valid;
         Ex_MemWrite <= MemWrite & Id_Valid;
         Ex_ALUSrc   <= ALUSrc   & Id_Valid;
         Ex_RegWrite <= RegWrite & Id_Valid;
         Ex_ALUOp    <= Id_Valid ? ALUOp : 4'd0;
      end
   end

   // Data half: bubbles hold the previous payload, so only a real capture
   // updates it.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         Ex_ReadData1 <= '0;
         Ex_ReadData2 <= '0;
         Ex_SignExt   <= '0;
         Ex_PCPlus4   <= '0;
         Ex_Rs        <= '0;
         Ex_Rt        <= '0;
         Ex_Rd        <= '0;
      end else if (!bubble) begin
         Ex_ReadData1 <= ReadData1;
         Ex_ReadData2 <= ReadData2;
         Ex_SignExt   <= SignExt;
         Ex_PCPlus4   <= PCPlus4;
         Ex_Rs        <= Id_Rs;
         Ex_Rt        <= Id_Rt;
         Ex_Rd        <= Id_Rd;
      end
   end

   // Only load-use bubbles count (Stall already excludes flushed cycles).
   // The counter sticks at all-ones.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         StallCount <= '0;
      end else if (Stall && (StallCount != {CNT_W{1'b1}})) begin
         StallCount <= StallCount + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
//
// Directed bench for id_ex_stage. Each driven ID slot pushes the EX-stage
// contents it must produce onto exp_q. After the capturing edge, that entry
// is popped and compared with the DUT outputs. Stall is checked
// combinationally before each edge. The counter width is 4, so the run can
// reach saturation.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

   localparam int DATA_W = 32;
   localparam int REG_W  = 5;
   localparam int CNT_W  = 4;

   // ---------------- DUT signals ----------------
   logic              Clk, Rst_n, Id_Valid, Flush;
   logic              RegDst, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite;
   logic [3:0]        ALUOp;
   logic [DATA_W-1:0] ReadData1, ReadData2, SignExt, PCPlus4;
   logic [REG_W-1:0]  Id_Rs, Id_Rt, Id_Rd;
   logic              Ex_RegDst, Ex_Branch, Ex_MemRead, Ex_MemtoReg, Ex_MemWrite;
   logic              Ex_ALUSrc, Ex_RegWrite;
   logic [3:0]        Ex_ALUOp;
   logic [DATA_W-1:0] Ex_ReadData1, Ex_ReadData2, Ex_SignExt, Ex_PCPlus4;
   logic [REG_W-1:0]  Ex_Rs, Ex_Rt, Ex_Rd;
   logic              Ex_Valid, Stall;
   logic [CNT_W-1:0]  StallCount;

   id_ex_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .Id_Valid(Id_Valid), .Flush(Flush),
      .RegDst(RegDst), .Branch(Branch), .MemRead(MemRead), .MemtoReg(MemtoReg),
      .MemWrite(MemWrite), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .ALUOp(ALUOp),
      .ReadData1(ReadData1), .ReadData2(ReadData2), .SignExt(SignExt),
      .PCPlus4(PCPlus4), .Id_Rs(Id_Rs), .Id_Rt(Id_Rt), .Id_Rd(Id_Rd),
      .Ex_RegDst(Ex_RegDst), .Ex_Branch(Ex_Branch), .Ex_MemRead(Ex_MemRead),
      .Ex_MemtoReg(Ex_MemtoReg), .Ex_MemWrite(Ex_MemWrite), .Ex_ALUSrc(Ex_ALUSrc),
      .Ex_RegWrite(Ex_RegWrite), .Ex_ALUOp(Ex_ALUOp), .Ex_ReadData1(Ex_ReadData1),
      .Ex_ReadData2(Ex_ReadData2), .Ex_SignExt(Ex_SignExt), .Ex_PCPlus4(Ex_PCPlus4),
      .Ex_Rs(Ex_Rs), .Ex_Rt(Ex_Rt), .Ex_Rd(Ex_Rd), .Ex_Valid(Ex_Valid),
      .Stall(Stall), .StallCount(StallCount)
   );

   // ---------------- slot / expectation types ----------------
   typedef struct packed {
      logic              valid;
      logic              regdst;
      logic              branch;
      logic              memread;
      logic              memtoreg;
      logic              memwrite;
      logic              alusrc;
      logic              regwrite;
      logic [3:0]        aluop;
      logic [DATA_W-1:0] rd1;
      logic [DATA_W-1:0] rd2;
      logic [DATA_W-1:0] sext;
      logic [DATA_W-1:0] pc4;
      logic [REG_W-1:0]  rs;
      logic [REG_W-1:0]  rt;
      logic [REG_W-1:0]  rd;
   } instr_t;

   typedef struct packed {
      instr_t           slot;
      logic [CNT_W-1:0] cnt;
   } ex_t;

   localparam int EXP_W = $bits(ex_t);

   logic [EXP_W-1:0] exp_q[$];
   int               checks = 0;
   int               errors = 0;
   int               exp_cnt = 0;
   instr_t           cur;
   instr_t           held;
   logic [31:0]      pc = 32'h0040_0000;

   // ---------------- clock / reset ----------------
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- helpers ----------------
   function automatic logic [31:0] rnd();
      return 32'($urandom_range(0, 65535));
   endfunction

   function automatic instr_t mk(input logic v, rdst, br, mr, mw, asrc, rw,
                                 input logic [3:0] op, input logic [31:0] a, b,
                                 input logic [4:0] rs, rt, rd);
      instr_t x;
      x          = '0;
      x.valid    = v;
      x.regdst   = rdst;
      x.branch   = br;
      x.memread  = mr;
      x.memtoreg = mr;
      x.memwrite = mw;
      x.alusrc   = asrc;
      x.regwrite = rw;
      x.aluop    = op;
      x.rd1      = a;
      x.rd2      = b;
      x.sext     = b ^ 32'h0F0F_1234;
      x.rs       = rs;
      x.rt       = rt;
      x.rd       = rd;
      return x;
   endfunction

   function automatic instr_t r_type(input logic [3:0] op, input logic [31:0] a, b,
                                     input logic [4:0] rs, rt, rd);
      return mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, op, a, b, rs, rt, rd);
   endfunction

   function automatic instr_t lw(input logic [31:0] a, input logic [4:0] rs, rt);
      return mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd2, a, rnd(), rs, rt, 5'd0);
   endfunction

   function automatic instr_t sw(input logic [31:0] a, b, input logic [4:0] rs, rt);
      return mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2, a, b, rs, rt, 5'd0);
   endfunction

   function automatic instr_t addi(input logic [31:0] a, input logic [4:0] rs, rt);
      return mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd2, a, rnd(), rs, rt, 5'd0);
   endfunction

   function automatic instr_t beq(input logic [31:0] a, b, input logic [4:0] rs, rt);
      return mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd6, a, b, rs, rt, 5'd0);
   endfunction

   function automatic instr_t kill(input instr_t x);
      instr_t y;
      y          = x;
      y.valid    = 1'b0;
      y.regdst   = 1'b0;
      y.branch   = 1'b0;
      y.memread  = 1'b0;
      y.memtoreg = 1'b0;
      y.memwrite = 1'b0;
      y.alusrc   = 1'b0;
      y.regwrite = 1'b0;
      y.aluop    = 4'd0;
      return y;
   endfunction

   function automatic ex_t ex_now();
      ex_t e;
      e.slot = {Ex_Valid, Ex_RegDst, Ex_Branch, Ex_MemRead, Ex_MemtoReg, Ex_MemWrite,
                Ex_ALUSrc, Ex_RegWrite, Ex_ALUOp, Ex_ReadData1, Ex_ReadData2,
                Ex_SignExt, Ex_PCPlus4, Ex_Rs, Ex_Rt, Ex_Rd};
      e.cnt  = StallCount;
      return e;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive(input instr_t i);
      i.pc4     = pc;
      pc        = pc + 32'd4;
      cur       = i;
      Id_Valid  = i.valid;
      RegDst    = i.regdst;
      Branch    = i.branch;
      MemRead   = i.memread;
      MemtoReg  = i.memtoreg;
      MemWrite  = i.memwrite;
      ALUSrc    = i.alusrc;
      RegWrite  = i.regwrite;
      ALUOp     = i.aluop;
      ReadData1 = i.rd1;
      ReadData2 = i.rd2;
      SignExt   = i.sext;
      PCPlus4   = i.pc4;
      Id_Rs     = i.rs;
      Id_Rt     = i.rt;
      Id_Rd     = i.rd;
   endtask

   // Current ID slot is expected to be captured at the next edge.
   task automatic expect_load();
      ex_t e;
      e.slot = cur.valid ? cur : kill(cur);
      e.cnt  = CNT_W'(exp_cnt);
      exp_q.push_back(e);
      held   = cur;
   endtask

   // A bubble is expected at the next edge: payload of the last capture held.
   task automatic expect_bubble();
      ex_t e;
      e.slot = kill(held);
      e.cnt  = CNT_W'(exp_cnt);
      exp_q.push_back(e);
   endtask

   task automatic check_stall(input string tag, input logic exp);
      #1;
      checks++;
      assert (Stall === exp) else begin
         errors++;
         $error("FAIL %s: Stall observed=%0b expected=%0b", tag, Stall, exp);
      end
   endtask

   task automatic check_now(input string tag, input ex_t exp);
      ex_t act;
      act = ex_now();
      checks++;
      assert (act === exp) else begin
         errors++;
         $error("FAIL %s: ex observed=%h expected=%h", tag, act, exp);
      end
   endtask

   // Scoreboard: advance one edge, then pop and compare the oldest expectation.
   task automatic step(input string tag);
      logic [EXP_W-1:0] exp;
      ex_t              act;
      @(posedge Clk);
      #1;
      checks++;
      assert (exp_q.size() != 0) else begin
         errors++;
         $error("FAIL %s: queue observed=empty expected=entry", tag);
      end
      if (exp_q.size() != 0) begin
         exp = exp_q.pop_front();
         act = ex_now();
         checks++;
         assert (act === exp) else begin
            errors++;
            $error("FAIL %s: ex observed=%h expected=%h", tag, act, exp);
         end
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      held  = '0;
      Flush = 1'b0;
      Rst_n = 1'b0;
      drive(r_type(4'd2, 32'hDEAD_BEEF, 32'h1234_5678, 5'd3, 5'd4, 5'd5));
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      Rst_n = 1'b1;
      #1;
      check_now("reset_state", '0);
      check_stall("reset_stall", 1'b0);

      // Pass-through ADD
      drive(r_type(4'd2, 32'h12, 32'h34, 5'd1, 5'd2, 5'd9));
      check_stall("add_nostall", 1'b0);
      expect_load();
      step("pass_add");

      // Load-use on Rs: one bubble, then the dependent ADD enters EX
      drive(lw(rnd(), 5'd3, 5'd8));
      check_stall("lw_nostall", 1'b0);
      expect_load();
      step("lw_load");
      drive(r_type(4'd2, rnd(), rnd(), 5'd8, 5'd4, 5'd10));
      check_stall("loaduse_rs", 1'b1);
      exp_cnt++;
      expect_bubble();
      step("loaduse_bubble");
      check_stall("after_bubble", 1'b0);
      expect_load();
      step("dependent_enters");

      // Rt usage, then flush priority
      drive(lw(rnd(), 5'd3, 5'd8));
      check_stall("lw2_nostall", 1'b0);
      expect_load();
      step("lw2_load");
      drive(addi(rnd(), 5'd5, 5'd8));
      check_stall("addi_rt_nostall", 1'b0);
      drive(sw(rnd(), rnd(), 5'd5, 5'd8));
      check_stall("sw_rt_stall", 1'b1);
      drive(r_type(4'd6, rnd(), rnd(), 5'd6, 5'd8, 5'd11));
      check_stall("rtype_rt_stall", 1'b1);
      Flush = 1'b1;
      drive(r_type(4'd2, rnd(), rnd(), 5'd8, 5'd7, 5'd12));
      check_stall("flush_hz_nostall", 1'b0);
      expect_bubble();
      step("flush_bubble");
      Flush = 1'b0;

      // Load to $zero never stalls; BEQ exercises Branch
      drive(lw(rnd(), 5'd8, 5'd0));
      check_stall("lw_zero_load", 1'b0);
      expect_load();
      step("lw_zero");
      drive(beq(rnd(), rnd(), 5'd0, 5'd0));
      check_stall("zero_nostall", 1'b0);
      expect_load();
      step("beq_pass");

      // Invalid ID slot: no stall, zero controls, payload still captured
      drive(lw(rnd(), 5'd2, 5'd8));
      check_stall("lw3_nostall", 1'b0);
      expect_load();
      step("lw3_load");
      begin
         instr_t dead;
         dead       = r_type(4'd7, rnd(), rnd(), 5'd8, 5'd8, 5'd13);
         dead.valid = 1'b0;
         drive(dead);
      end
      check_stall("invalid_nostall", 1'b0);
      expect_load();
      step("invalid_slot");

      // Asynchronous reset in the middle of a stall
      drive(lw(rnd(), 5'd2, 5'd8));
      check_stall("lw4_nostall", 1'b0);
      expect_load();
      step("lw4_load");
      drive(r_type(4'd1, rnd(), rnd(), 5'd8, 5'd9, 5'd14));
      check_stall("midstall_pre", 1'b1);
      #1;
      Rst_n = 1'b0;
      check_stall("midstall_reset_stall", 1'b0);
      check_now("midstall_reset_state", '0);
      @(negedge Clk);
      Rst_n   = 1'b1;
      exp_cnt = 0;
      held    = '0;

      // Saturation: 20 load-use hazards on a 4-bit counter
      for (int i = 0; i < 20; i++) begin
         drive(lw(rnd(), 5'd1, 5'd8));
         check_stall("sat_lw_nostall", 1'b0);
         expect_load();
         step("sat_lw");
         drive(r_type(4'd12, rnd(), rnd(), 5'd8, 5'd3, 5'd15));
         check_stall("sat_stall", 1'b1);
         if (exp_cnt < 15) exp_cnt++;
         expect_bubble();
         step("sat_bubble");
      end
      checks++;
      assert (StallCount === 4'd15) else begin
         errors++;
         $error("FAIL sat_final: StallCount observed=%0d expected=15", StallCount);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
